// File: rtl/display_timing_pkg.sv
// Shared timing types, reset-time defaults and helpers for display_timing_gen.
package display_timing_pkg;

    // Storage width of one timing field and of sums of up to four such fields.
    localparam int TIM_W = 16;
    localparam int SUM_W = TIM_W + 2;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam bit POL_LOW  = 1'b0;
    localparam bit POL_HIGH = 1'b1;

    typedef struct packed {
        logic [TIM_W-1:0] active;
        logic [TIM_W-1:0] fp;
        logic [TIM_W-1:0] sync;
        logic [TIM_W-1:0] bp;
    } timing_t;

    function automatic logic [SUM_W-1:0] timing_total(input timing_t t);
        return SUM_W'(t.active) + SUM_W'(t.fp) + SUM_W'(t.sync) + SUM_W'(t.bp);
    endfunction

    // A period of exactly 2^cordw still fits, since positions only reach total-1.
    function automatic logic timing_ok(input timing_t t, input int cordw);
        return (t.active != '0) && (t.sync != '0) &&
               (timing_total(t) <= (SUM_W'(1) << cordw));
    endfunction

endpackage

// File: rtl/timing_axis.sv
// One display axis: a wrapping position counter plus the active/sync decode
// of the position it is about to load.
module timing_axis
    import display_timing_pkg::*;
#(
    parameter int               CORDW    = 10,
    parameter logic [CORDW-1:0] INIT_POS = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    input  logic [SUM_W-1:0] last,
    input  logic [SUM_W-1:0] act_len,
    input  logic [SUM_W-1:0] sync_beg,
    input  logic [SUM_W-1:0] sync_end,
    output logic [CORDW-1:0] pos,
    output logic             at_end,
    output logic             act_nxt,
    output logic             sync_nxt
);

    logic [CORDW-1:0] pos_nxt;
    logic [SUM_W-1:0] nxt_w;

    // last refers to the running period; the window bounds refer to the
    // timing that will own pos_nxt, which differs only on a timing switch.
    always_comb begin
        at_end  = (SUM_W'(pos) == last);
        pos_nxt = pos;
        if (adv) begin
            pos_nxt = at_end ? '0 : pos + CORDW'(1);
        end
        nxt_w    = SUM_W'(pos_nxt);
        act_nxt  = (nxt_w < act_len);
        sync_nxt = (nxt_w >= sync_beg) && (nxt_w < sync_end);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos <= INIT_POS;
        end else begin
            pos <= pos_nxt;
        end
    end

endmodule

// File: rtl/display_timing_gen.sv
// Display timing generator: pixel/line counters, de/sync decode, frame strobes
// and a shadowed timing configuration that switches only between frames.
module display_timing_gen
    import display_timing_pkg::*;
#(
    parameter int CORDW    = 10,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit H_POL    = POL_LOW,
    parameter bit V_POL    = POL_LOW
) (
    input  logic             pix_clk,
    input  logic             rst_pix_n,
    input  logic             en,
    input  logic [CORDW-1:0] cfg_h_active,
    input  logic [CORDW-1:0] cfg_h_fp,
    input  logic [CORDW-1:0] cfg_h_sync,
    input  logic [CORDW-1:0] cfg_h_bp,
    input  logic [CORDW-1:0] cfg_v_active,
    input  logic [CORDW-1:0] cfg_v_fp,
    input  logic [CORDW-1:0] cfg_v_sync,
    input  logic [CORDW-1:0] cfg_v_bp,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic             de,
    output logic             hsync,
    output logic             vsync,
    output logic             line_start,
    output logic             frame_start,
    output logic [15:0]      frame_cnt
);

    localparam timing_t DEF_H = '{active: TIM_W'(H_ACTIVE), fp: TIM_W'(H_FP),
                                  sync: TIM_W'(H_SYNC), bp: TIM_W'(H_BP)};
    localparam timing_t DEF_V = '{active: TIM_W'(V_ACTIVE), fp: TIM_W'(V_FP),
                                  sync: TIM_W'(V_SYNC), bp: TIM_W'(V_BP)};
    localparam logic [CORDW-1:0] H_INIT = CORDW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CORDW-1:0] V_INIT = CORDW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    timing_t          cur_h, cur_v, pend_h, pend_v, req_h, req_v;
    logic             h_end, v_end, h_act, v_act, h_sync, v_sync;
    logic             frame_end, apply, xfer, req_ok;
    logic [TIM_W-1:0] h_n_act, h_n_fp, h_n_sync, v_n_act, v_n_fp, v_n_sync;
    logic [SUM_W-1:0] h_last, h_sb, h_se, v_last, v_sb, v_se;

    always_comb begin
        req_h.active = TIM_W'(cfg_h_active);
        req_h.fp     = TIM_W'(cfg_h_fp);
        req_h.sync   = TIM_W'(cfg_h_sync);
        req_h.bp     = TIM_W'(cfg_h_bp);
        req_v.active = TIM_W'(cfg_v_active);
        req_v.fp     = TIM_W'(cfg_v_fp);
        req_v.sync   = TIM_W'(cfg_v_sync);
        req_v.bp     = TIM_W'(cfg_v_bp);
        req_ok = timing_ok(req_h, CORDW) && timing_ok(req_v, CORDW);
        xfer   = cfg_valid && cfg_ready;

        // A pending set exists exactly while cfg_ready is low.
        frame_end = en && h_end && v_end;
        apply     = frame_end && !cfg_ready;

        // Decode windows follow the timing that will own the next position.
        h_n_act  = apply ? pend_h.active : cur_h.active;
        h_n_fp   = apply ? pend_h.fp     : cur_h.fp;
        h_n_sync = apply ? pend_h.sync   : cur_h.sync;
        v_n_act  = apply ? pend_v.active : cur_v.active;
        v_n_fp   = apply ? pend_v.fp     : cur_v.fp;
        v_n_sync = apply ? pend_v.sync   : cur_v.sync;

        h_last = timing_total(cur_h) - SUM_W'(1);
        h_sb   = SUM_W'(h_n_act) + SUM_W'(h_n_fp);
        h_se   = h_sb + SUM_W'(h_n_sync);
        v_last = timing_total(cur_v) - SUM_W'(1);
        v_sb   = SUM_W'(v_n_act) + SUM_W'(v_n_fp);
        v_se   = v_sb + SUM_W'(v_n_sync);
    end

    timing_axis #(.CORDW(CORDW), .INIT_POS(H_INIT)) u_h_axis (
        .clk      (pix_clk),
        .rst_n    (rst_pix_n),
        .adv      (en),
        .last     (h_last),
        .act_len  (SUM_W'(h_n_act)),
        .sync_beg (h_sb),
        .sync_end (h_se),
        .pos      (sx),
        .at_end   (h_end),
        .act_nxt  (h_act),
        .sync_nxt (h_sync)
    );

    timing_axis #(.CORDW(CORDW), .INIT_POS(V_INIT)) u_v_axis (
        .clk      (pix_clk),
        .rst_n    (rst_pix_n),
        .adv      (en && h_end),
        .last     (v_last),
        .act_len  (SUM_W'(v_n_act)),
        .sync_beg (v_sb),
        .sync_end (v_se),
        .pos      (sy),
        .at_end   (v_end),
        .act_nxt  (v_act),
        .sync_nxt (v_sync)
    );

    always_ff @(posedge pix_clk or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            cur_h       <= DEF_H;
            cur_v       <= DEF_V;
            pend_h      <= '0;
            pend_v      <= '0;
            cfg_ready   <= 1'b1;
            cfg_err     <= 1'b0;
            de          <= 1'b0;
            hsync       <= ~H_POL;
            vsync       <= ~V_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            cfg_err <= xfer && !req_ok;
            if (xfer && req_ok) begin
                pend_h    <= req_h;
                pend_v    <= req_v;
                cfg_ready <= 1'b0;
            end else if (apply) begin
                cur_h     <= pend_h;
                cur_v     <= pend_v;
                cfg_ready <= 1'b1;
            end
            line_start  <= en && h_end;
            frame_start <= frame_end;
            if (frame_end) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (en) begin
                de    <= h_act && v_act;
                hsync <= h_sync ? H_POL : ~H_POL;
                vsync <= v_sync ? V_POL : ~V_POL;
            end
        end
    end

endmodule

// File: tb/tb_display_timing_gen.sv
// Randomized bench for display_timing_gen against a position/timing reference model.
module tb_display_timing_gen;

    localparam int CW = 6;
    localparam bit HP = 1'b1;
    localparam bit VP = 1'b0;

    typedef struct packed {
        logic [CW-1:0] ha, hf, hs, hb, va, vf, vs, vb;
    } tcfg_t;

    localparam tcfg_t DEF = '{ha: 6'd20, hf: 6'd3, hs: 6'd4, hb: 6'd5,
                              va: 6'd8,  vf: 6'd2, vs: 6'd2, vb: 6'd3};

    logic          pix_clk = 1'b0;
    logic          rst_pix_n, en, cfg_valid;
    logic [CW-1:0] cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp;
    logic [CW-1:0] cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp;
    logic          cfg_ready, cfg_err, de, hsync, vsync, line_start, frame_start;
    logic [CW-1:0] sx, sy;
    logic [15:0]   frame_cnt;

    int    n_checks = 0;
    int    n_pass   = 0;

    int    m_x, m_y, m_fcnt;
    tcfg_t m_cur, m_pend;
    bit    m_ready, m_ls, m_fs, m_err;

    always #5 pix_clk = ~pix_clk;

    display_timing_gen #(
        .CORDW(CW), .H_ACTIVE(20), .H_FP(3), .H_SYNC(4), .H_BP(5),
        .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .H_POL(HP), .V_POL(VP)
    ) dut (
        .pix_clk      (pix_clk),
        .rst_pix_n    (rst_pix_n),
        .en           (en),
        .cfg_h_active (cfg_h_active),
        .cfg_h_fp     (cfg_h_fp),
        .cfg_h_sync   (cfg_h_sync),
        .cfg_h_bp     (cfg_h_bp),
        .cfg_v_active (cfg_v_active),
        .cfg_v_fp     (cfg_v_fp),
        .cfg_v_sync   (cfg_v_sync),
        .cfg_v_bp     (cfg_v_bp),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_err      (cfg_err),
        .sx           (sx),
        .sy           (sy),
        .de           (de),
        .hsync        (hsync),
        .vsync        (vsync),
        .line_start   (line_start),
        .frame_start  (frame_start),
        .frame_cnt    (frame_cnt)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    endtask

    function automatic int htot(input tcfg_t c);
        return int'(c.ha) + int'(c.hf) + int'(c.hs) + int'(c.hb);
    endfunction

    function automatic int vtot(input tcfg_t c);
        return int'(c.va) + int'(c.vf) + int'(c.vs) + int'(c.vb);
    endfunction

    function automatic bit cfg_ok(input tcfg_t c);
        return (c.ha != 0) && (c.hs != 0) && (c.va != 0) && (c.vs != 0) &&
               (htot(c) <= (1 << CW)) && (vtot(c) <= (1 << CW));
    endfunction

    function automatic tcfg_t rand_cfg();
        tcfg_t c;
        int t;
        c.ha = CW'($urandom_range(0, 20));
        c.hf = CW'($urandom_range(0, 3));
        c.hs = CW'($urandom_range(0, 4));
        c.hb = CW'($urandom_range(0, 3));
        c.va = CW'($urandom_range(0, 8));
        c.vf = CW'($urandom_range(0, 2));
        c.vs = CW'($urandom_range(0, 2));
        c.vb = CW'($urandom_range(0, 2));
        // Push the line length onto the 2^CW limit (exactly 64 or one past it).
        if ($urandom_range(0, 3) == 0) begin
            t = 64 - int'(c.hf) - int'(c.hs) - int'(c.hb) + int'($urandom_range(0, 1));
            c.ha = CW'((t > 63) ? 63 : t);
        end
        return c;
    endfunction

    task automatic model_reset();
        m_cur   = DEF;
        m_pend  = '0;
        m_x     = htot(DEF) - 1;
        m_y     = vtot(DEF) - 1;
        m_fcnt  = 0;
        m_ready = 1'b1;
        m_ls    = 1'b0;
        m_fs    = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic model_step(input bit e, input bit v, input tcfg_t c);
        bit was_ready;
        bit ok;
        was_ready = m_ready;
        ok        = cfg_ok(c);
        m_err     = v && was_ready && !ok;
        m_ls      = 1'b0;
        m_fs      = 1'b0;
        if (e) begin
            if (m_x == htot(m_cur) - 1) begin
                m_x  = 0;
                m_ls = 1'b1;
                if (m_y == vtot(m_cur) - 1) begin
                    m_y    = 0;
                    m_fs   = 1'b1;
                    m_fcnt = (m_fcnt + 1) % 65536;
                    if (!was_ready) begin
                        m_cur   = m_pend;
                        m_ready = 1'b1;
                    end
                end else begin
                    m_y++;
                end
            end else begin
                m_x++;
            end
        end
        if (v && was_ready && ok) begin
            m_pend  = c;
            m_ready = 1'b0;
        end
    endtask

    task automatic check_outputs();
        int  hs0, hs1, vs0, vs1;
        bit  in_hs, in_vs, exp_de;
        hs0    = int'(m_cur.ha) + int'(m_cur.hf);
        hs1    = hs0 + int'(m_cur.hs);
        vs0    = int'(m_cur.va) + int'(m_cur.vf);
        vs1    = vs0 + int'(m_cur.vs);
        in_hs  = (m_x >= hs0) && (m_x < hs1);
        in_vs  = (m_y >= vs0) && (m_y < vs1);
        exp_de = (m_x < int'(m_cur.ha)) && (m_y < int'(m_cur.va));
        check("sx", int'(sx), m_x);
        check("sy", int'(sy), m_y);
        check("de", int'(de), int'(exp_de));
        check("hsync", int'(hsync), int'(in_hs ? HP : !HP));
        check("vsync", int'(vsync), int'(in_vs ? VP : !VP));
        check("line_start", int'(line_start), int'(m_ls));
        check("frame_start", int'(frame_start), int'(m_fs));
        check("frame_cnt", int'(frame_cnt), m_fcnt);
        check("cfg_ready", int'(cfg_ready), int'(m_ready));
        check("cfg_err", int'(cfg_err), int'(m_err));
    endtask

    task automatic drive_cfg(input tcfg_t c);
        cfg_h_active = c.ha;
        cfg_h_fp     = c.hf;
        cfg_h_sync   = c.hs;
        cfg_h_bp     = c.hb;
        cfg_v_active = c.va;
        cfg_v_fp     = c.vf;
        cfg_v_sync   = c.vs;
        cfg_v_bp     = c.vb;
    endtask

    // Called at a falling edge: drive, clock, advance the model, then compare.
    task automatic cycle(input bit e, input bit v, input tcfg_t c);
        en        = e;
        cfg_valid = v;
        drive_cfg(c);
        @(posedge pix_clk);
        model_step(e, v, c);
        @(negedge pix_clk);
        check_outputs();
    endtask

    initial begin
        tcfg_t c;
        int    k, n_de, n_hs, n_vs;
        bit    r_e, r_v;

        rst_pix_n = 1'b0;
        en        = 1'b0;
        cfg_valid = 1'b0;
        drive_cfg(DEF);
        repeat (3) @(posedge pix_clk);
        @(negedge pix_clk);
        model_reset();
        check_outputs();
        rst_pix_n = 1'b1;

        cycle(1'b1, 1'b0, DEF);
        repeat (40) cycle(1'b1, 1'b0, DEF);
        repeat (50) cycle(1'b0, 1'b0, DEF);
        repeat (5) cycle(1'b1, 1'b0, DEF);

        c = DEF;
        c.hs = '0;
        cycle(1'b1, 1'b1, c);
        c = '{ha: 6'd4, hf: 6'd1, hs: 6'd2, hb: 6'd1, va: 6'd3, vf: 6'd1, vs: 6'd1, vb: 6'd1};
        cycle(1'b1, 1'b1, c);
        repeat (5) cycle(1'b1, 1'b1, rand_cfg());
        repeat (500) cycle(1'b1, 1'b0, DEF);

        // Measure one whole 8x6 frame starting at its first pixel.
        k = 0;
        while (!m_fs && k < 100) begin
            cycle(1'b1, 1'b0, DEF);
            k++;
        end
        n_de = int'(de);
        n_hs = int'(hsync == HP);
        n_vs = int'(vsync == VP);
        repeat (47) begin
            cycle(1'b1, 1'b0, DEF);
            n_de += int'(de);
            n_hs += int'(hsync == HP);
            n_vs += int'(vsync == VP);
        end
        check("small_frame_de_cycles", n_de, 12);
        check("small_frame_hsync_cycles", n_hs, 12);
        check("small_frame_vsync_cycles", n_vs, 8);

        repeat (5000) begin
            r_e = ($urandom_range(0, 9) != 0);
            r_v = ($urandom_range(0, 19) == 0);
            cycle(r_e, r_v, rand_cfg());
        end

        // Asynchronous reset right after a configuration has been accepted.
        k = 0;
        while (!m_ready && k < 2000) begin
            cycle(1'b1, 1'b0, DEF);
            k++;
        end
        c = '{ha: 6'd10, hf: 6'd2, hs: 6'd3, hb: 6'd1, va: 6'd5, vf: 6'd1, vs: 6'd1, vb: 6'd1};
        cycle(1'b1, 1'b1, c);
        #2 rst_pix_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge pix_clk);
        rst_pix_n = 1'b1;
        cycle(1'b1, 1'b0, DEF);
        repeat (80) cycle(1'b1, 1'b0, DEF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/display_timing_gen.md
DISPLAY_TIMING_GEN -- requirements
Module: display_timing_gen

Interface
REQ-001 The block SHALL have parameter CORDW, default 10, giving the width of all coordinate and timing fields.
REQ-002 The block SHALL have parameters H_ACTIVE/H_FP/H_SYNC/H_BP, defaults 640/16/96/48, giving the reset-time horizontal timing.
REQ-003 The block SHALL have parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, giving the reset-time vertical timing.
REQ-004 The block SHALL have parameters H_POL and V_POL, default 0, giving sync polarity (0 = active-low, 1 = active-high).
REQ-005 The block SHALL have port pix_clk, input, width 1: the single pixel clock.
REQ-006 The block SHALL have port rst_pix_n, input, width 1: the reset, asynchronous and active-low.
REQ-007 The block SHALL have port en, input, width 1: when high, the counters advance.
REQ-008 The block SHALL have ports cfg_h_active/cfg_h_fp/cfg_h_sync/cfg_h_bp, input, width CORDW each: the new horizontal timing.
REQ-009 The block SHALL have ports cfg_v_active/cfg_v_fp/cfg_v_sync/cfg_v_bp, input, width CORDW each: the new vertical timing.
REQ-010 The block SHALL have port cfg_valid, input, width 1, and port cfg_ready, output, width 1: the configuration handshake.
REQ-011 The block SHALL have port cfg_err, output, width 1: a one-cycle pulse when a configuration is rejected.
REQ-012 The block SHALL have ports sx and sy, output, width CORDW each: the current pixel position.
REQ-013 The block SHALL have ports de, hsync and vsync, output, width 1 each: data enable and the sync signals.
REQ-014 The block SHALL have ports line_start and frame_start, output, width 1 each: one-cycle strobes.
REQ-015 The block SHALL have port frame_cnt, output, width 16: the number of completed frames, wrapping at 2^16.

Function
REQ-016 The line order SHALL be active, front porch, sync, back porch.
- sx counts 0..h_total-1, where h_total = h_active + h_fp + h_sync + h_bp.
- sy counts 0..v_total-1, defined the same way from the vertical fields.
REQ-017 On an enabled edge, sx SHALL increment; at h_total-1 it SHALL wrap to 0 and sy SHALL increment.
- sy SHALL wrap from v_total-1 to 0.
REQ-018 With en low, every counter and output SHALL hold its value, and the strobes SHALL be 0.
REQ-019 de SHALL be 1 exactly when sx < h_active and sy < v_active.
REQ-020 hsync SHALL be asserted exactly for h_active+h_fp <= sx < h_active+h_fp+h_sync; vsync SHALL follow the same rule on sy.
- Asserted level = H_POL / V_POL.
REQ-021 All outputs SHALL be registered and describe the same (sx, sy) they accompany; there is no extra latency between a position and its de/sync.
REQ-022 line_start SHALL be 1 when sx = 0; frame_start SHALL be 1 when sx = 0 and sy = 0.
REQ-023 frame_cnt SHALL increment on the same edge that produces frame_start.
REQ-024 A configuration SHALL transfer when cfg_valid and cfg_ready are both high on an edge, and SHALL be captured into a pending shadow set.
REQ-025 cfg_ready SHALL be 1 while no configuration is pending, and 0 from the transfer until the pending set is applied.
REQ-026 A pending set SHALL become active on the enabled edge that leaves (h_total-1, v_total-1).
- The first pixel of the new frame uses the new timing; a frame never mixes timings.
REQ-027 A configuration with any active or sync field equal to 0, or with either total > 2^CORDW, SHALL be rejected.
- cfg_err pulses for one cycle on the transfer edge, nothing is pending, and cfg_ready stays 1.
REQ-028 Porch fields of 0 SHALL be legal.
REQ-029 Totals SHALL be computed at CORDW+1 bits, so a total of exactly 2^CORDW is legal.
REQ-030 A transfer on the same edge that applies a previous pending set is impossible, because cfg_ready is 0 then; no other simultaneous case exists.

Reset
REQ-031 While rst_pix_n is low, the active timing SHALL equal the parameter defaults, and the pending set SHALL be cleared.
REQ-032 While rst_pix_n is low, the outputs SHALL be:
- sx = h_total-1, sy = v_total-1 (799/524 by default);
- de = 0, hsync = !H_POL, vsync = !V_POL;
- strobes = 0, cfg_err = 0, frame_cnt = 0, cfg_ready = 1.
REQ-033 The first enabled edge after reset release SHALL produce (0, 0) with frame_start = 1 and frame_cnt = 1.
REQ-034 Reset asserted mid-frame or with a configuration pending SHALL discard the pending set and restore the default timing.

Structure
REQ-035 Package display_timing_pkg SHALL hold:
- the default timing constants;
- the timing_t struct (active/fp/sync/bp);
- the polarity constants.
REQ-036 One sub-module, timing_axis, SHALL implement a single counter with its active and sync decode, instantiated once horizontally and once vertically (vertical advanced by the horizontal wrap).
REQ-037 The shadow and apply logic SHALL stay in the top level.

Verification
REQ-038 Defaults, en = 1, one frame: exactly 420000 cycles between frame_start pulses; de high on 307200 cycles; hsync low for 96 cycles at sx 656..751.
REQ-039 Apply config 4/1/2/1 by 3/1/1/1 mid-frame: cfg_ready drops; the current frame stays 800x525; the next frame has an 8x6 period; hsync is asserted at sx 5..6 and vsync at sy 4.
REQ-040 Config with cfg_h_sync = 0: cfg_err pulses once, cfg_ready stays 1, timing is unchanged.
REQ-041 Hold en low for 50 cycles mid-line: sx, sy and the outputs are frozen, no strobes; counting resumes from the same position.
REQ-042 Assert rst_pix_n low asynchronously mid-frame with a config pending: outputs take reset values immediately; after release, (0, 0) with frame_start and the default timing.
REQ-043 H_POL = 1, V_POL = 1 build: sync levels are inverted relative to REQ-038, and de is unchanged.
